// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared types and helpers for the SPI register-bank slave
//
// Contents:
//   state_t            frame FSM states (IDLE, HDR, WDATA, RDATA, DONE)
//   RW_READ/RW_WRITE   encodings of the header R/W bit
//   cnt_width()        width of the frame bit counter (never wraps within a frame)

package spi_regbank_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic int cnt_width(input int hdr_w, input int data_w);
        return $clog2(hdr_w + data_w + 1);
    endfunction

endpackage

// File: rtl/spi_regbank_if.sv
// rtl/spi_regbank_if.sv - SPI pin bundle between host (master) and register-bank slave
//
// Signals:
//   SEN     serial enable, active-low (host drives)
//   SDI     serial data in, MSB first (host drives)
//   SDO     serial read data, MSB first (slave drives)
//   SDO_OE  SDO pad drive enable (slave drives)

interface spi_regbank_if;
    logic SEN;
    logic SDI;
    logic SDO;
    logic SDO_OE;

    modport master (output SEN, output SDI, input SDO, input SDO_OE);
    modport slave  (input SEN, input SDI, output SDO, output SDO_OE);
endinterface

// File: rtl/spi_regbank_mem.sv
// rtl/spi_regbank_mem.sv - DEPTH x DATA_W register array, range-checked write, combinational read
//
// Ports:
//   clk    write clock
//   we     write enable; ignored when addr >= DEPTH
//   addr   ADDR_W-bit register address
//   wdata  write word
//   rdata  read word; 0 when addr >= DEPTH
// Contents are not reset.

module spi_regbank_mem #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    // Extra MSB so DEPTH == 2**ADDR_W is representable.
    assign in_range = {1'b0, addr} < DEPTH_L;
    assign idx      = addr[IDX_W-1:0];
    assign rdata    = in_range ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/spi_regbank_slave.sv
// rtl/spi_regbank_slave.sv - SPI slave with read/write register bank
//
// Ports:
//   SCLK       SPI clock; inputs sampled on rising edge, SDO driven on falling edge
//   Reset      asynchronous, active-high reset
//   spi        spi_regbank_if.slave: SEN (active-low), SDI, SDO, SDO_OE
//   wr_done    one-SCLK pulse when a write word is committed
//   rd_done    one-SCLK pulse when a read word has been fully shifted out
//   last_addr  address of the last completed access
//   last_data  data of the last completed access
// Frame: HDR_W header bits (MSB = R/W, 1 = read; low ADDR_W bits = address),
// then DATA_W data bits, all MSB first.
// Build option: define SPI_STREAM_EN for burst access (address auto-increments
// per word, wrapping modulo 2**ADDR_W); otherwise one word per frame.

module spi_regbank_slave
    import spi_regbank_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int HDR_W  = 16,
    parameter int DEPTH  = 4096
) (
    input  logic              SCLK,
    input  logic              Reset,
    spi_regbank_if.slave      spi,
    output logic              wr_done,
    output logic              rd_done,
    output logic [ADDR_W-1:0] last_addr,
    output logic [DATA_W-1:0] last_data
);

    localparam int CNT_W = cnt_width(HDR_W, DATA_W);

`ifdef SPI_STREAM_EN
    localparam logic STREAM = 1'b1;
`else
    localparam logic STREAM = 1'b0;
`endif

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [HDR_W-2:0]    hdr_sr;
    logic [HDR_W-1:0]    hdr_nx;
    logic [ADDR_W-1:0]   addr, addr_inc, mem_addr;
    logic [DATA_W-2:0]   wr_sr;
    logic [DATA_W-1:0]   wr_word, rd_word, rd_sr, mem_rdata;
    logic                sen, sdo_q, sdo_oe_q;
    logic                hdr_last, word_last;
    logic                hdr_shift, hdr_latch, commit_wr, commit_rd;

    assign sen        = spi.SEN;
    assign spi.SDO    = sdo_q;
    assign spi.SDO_OE = sdo_oe_q;

    // Header and write word including the bit arriving on this rising edge.
    assign hdr_nx    = {hdr_sr, spi.SDI};
    assign wr_word   = {wr_sr, spi.SDI};
    assign addr_inc  = addr + ADDR_W'(1);
    assign hdr_last  = (cnt == CNT_W'(HDR_W - 1));
    assign word_last = (cnt == CNT_W'(HDR_W + DATA_W - 1));

    always_comb begin
        state_nx  = state;
        hdr_shift = 1'b0;
        hdr_latch = 1'b0;
        commit_wr = 1'b0;
        commit_rd = 1'b0;
        mem_addr  = hdr_nx[ADDR_W-1:0];
        case (state)
            IDLE: begin
                // The first rising edge of a frame already carries header bit 1.
                hdr_shift = 1'b1;
                state_nx  = HDR;
            end
            HDR: begin
                hdr_shift = 1'b1;
                if (hdr_last) begin
                    hdr_latch = 1'b1;
                    case (hdr_nx[HDR_W-1])
                        RW_READ:  state_nx = RDATA;
                        RW_WRITE: state_nx = WDATA;
                    endcase
                end
            end
            WDATA: begin
                mem_addr = addr;
                if (word_last) begin
                    commit_wr = 1'b1;
                    state_nx  = STREAM ? WDATA : DONE;
                end
            end
            RDATA: begin
                // Prefetch of the next burst word happens on the last edge of this one.
                mem_addr = addr_inc;
                if (word_last) begin
                    commit_rd = 1'b1;
                    state_nx  = STREAM ? RDATA : DONE;
                end
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // SEN high aborts the frame: only frame-scoped state is cleared here.
    always_ff @(posedge SCLK or posedge Reset or posedge sen) begin
        if (Reset || sen) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge SCLK or posedge Reset or posedge sen) begin
        if (Reset || sen) begin
            cnt <= '0;
        end else if (state != DONE) begin
            if ((commit_wr || commit_rd) && STREAM) begin
                cnt <= CNT_W'(HDR_W);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge SCLK or posedge Reset) begin
        if (Reset) begin
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            hdr_sr    <= '0;
            addr      <= '0;
            wr_sr     <= '0;
            rd_word   <= '0;
            rd_sr     <= '0;
            last_addr <= '0;
            last_data <= '0;
        end else begin
            wr_done <= commit_wr;
            rd_done <= commit_rd;
            if (hdr_shift) begin
                hdr_sr <= hdr_nx[HDR_W-2:0];
            end
            if (hdr_latch) begin
                addr <= hdr_nx[ADDR_W-1:0];
            end else if ((commit_wr || commit_rd) && STREAM) begin
                addr <= addr_inc;
            end
            if (state == WDATA) begin
                wr_sr <= wr_word[DATA_W-2:0];
            end
            if (hdr_latch || (commit_rd && STREAM)) begin
                rd_word <= mem_rdata;
                rd_sr   <= mem_rdata;
            end else if (state == RDATA) begin
                rd_sr <= rd_sr << 1;
            end
            if (commit_wr) begin
                last_addr <= addr;
                last_data <= wr_word;
            end else if (commit_rd) begin
                last_addr <= addr;
                last_data <= rd_word;
            end
        end
    end

    // SDO launches on the falling edge so the host can sample on the next rising edge.
    always_ff @(negedge SCLK or posedge Reset or posedge sen) begin
        if (Reset || sen) begin
            sdo_q    <= 1'b0;
            sdo_oe_q <= 1'b0;
        end else begin
            sdo_oe_q <= (state == RDATA);
            sdo_q    <= (state == RDATA) ? rd_sr[DATA_W-1] : 1'b0;
        end
    end

    spi_regbank_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (SCLK),
        .we    (commit_wr),
        .addr  (mem_addr),
        .wdata (wr_word),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_spi_regbank_slave.sv
// tb/tb_spi_regbank_slave.sv - self-checking bench for spi_regbank_slave (DEPTH 4096 and 256 instances)

module tb_spi_regbank_slave;

`ifdef SPI_STREAM_EN
    localparam int EXTRA = 0;
`else
    localparam int EXTRA = 2;
`endif
    localparam int NVEC = 10;

    logic SCLK = 1'b0;
    logic Reset;

    spi_regbank_if spi_a ();
    spi_regbank_if spi_b ();

    logic        wr_done_a, rd_done_a, wr_done_b, rd_done_b;
    logic [11:0] last_addr_a, last_addr_b;
    logic [7:0]  last_data_a, last_data_b;

    assign spi_b.SEN = spi_a.SEN;
    assign spi_b.SDI = spi_a.SDI;

    spi_regbank_slave #(.ADDR_W(12), .DATA_W(8), .HDR_W(16), .DEPTH(4096)) dut_a (
        .SCLK      (SCLK),
        .Reset     (Reset),
        .spi       (spi_a.slave),
        .wr_done   (wr_done_a),
        .rd_done   (rd_done_a),
        .last_addr (last_addr_a),
        .last_data (last_data_a)
    );

    spi_regbank_slave #(.ADDR_W(12), .DATA_W(8), .HDR_W(16), .DEPTH(256)) dut_b (
        .SCLK      (SCLK),
        .Reset     (Reset),
        .spi       (spi_b.slave),
        .wr_done   (wr_done_b),
        .rd_done   (rd_done_b),
        .last_addr (last_addr_b),
        .last_data (last_data_b)
    );

    always #5 SCLK = ~SCLK;

    typedef struct {
        logic [15:0] hdr;
        logic [7:0]  din;
        logic [7:0]  exp_a;
        logic [7:0]  exp_b;
    } vec_t;

    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    int          wr_a, rd_a, wr_b, rd_b, oe_a, oe_b, pos_a;
    logic [15:0] word_a, word_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_bit(input logic b);
        @(negedge SCLK);
        #1;
        spi_a.SEN = 1'b0;
        spi_a.SDI = b;
        @(posedge SCLK);
        #1;
    endtask

    task automatic sample(input int i, input int nbits);
        if (i >= 16 && i < 32 && i < nbits) begin
            word_a = {word_a[14:0], spi_a.SDO};
            word_b = {word_b[14:0], spi_b.SDO};
        end
        if (spi_a.SDO_OE) oe_a++;
        if (spi_b.SDO_OE) oe_b++;
        if (wr_done_a) begin wr_a++; pos_a = i + 1; end
        if (rd_done_a) begin rd_a++; pos_a = i + 1; end
        if (wr_done_b) wr_b++;
        if (rd_done_b) rd_b++;
    endtask

    // Shifts nbits of a left-justified frame, optional extra clocks, then ends the frame.
    task automatic xfer(input logic [39:0] bits, input int nbits, input int extra);
        wr_a = 0; rd_a = 0; wr_b = 0; rd_b = 0; oe_a = 0; oe_b = 0; pos_a = 0;
        word_a = '0; word_b = '0;
        for (int i = 0; i < nbits + extra; i++) begin
            clk_bit((i < nbits) ? bits[39-i] : 1'b1);
            sample(i, nbits);
        end
        @(negedge SCLK);
        #1;
        spi_a.SEN = 1'b1;
        spi_a.SDI = 1'b0;
        @(posedge SCLK);
        #1;
        sample(99, nbits);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic is_rd;

        vecs[0] = '{16'h0123, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{16'h8123, 8'h00, 8'hA5, 8'h00};
        vecs[2] = '{16'h0300, 8'hFF, 8'h00, 8'h00};
        vecs[3] = '{16'h8300, 8'h00, 8'hFF, 8'h00};
        vecs[4] = '{16'h0040, 8'h5A, 8'h00, 8'h00};
        vecs[5] = '{16'h8040, 8'h00, 8'h5A, 8'h5A};
        vecs[6] = '{16'h7045, 8'h3C, 8'h00, 8'h00};
        vecs[7] = '{16'hF045, 8'h00, 8'h3C, 8'h3C};
        vecs[8] = '{16'h0FFF, 8'h81, 8'h00, 8'h00};
        vecs[9] = '{16'h8FFF, 8'h00, 8'h81, 8'h00};

        Reset     = 1'b1;
        spi_a.SEN = 1'b1;
        spi_a.SDI = 1'b0;
        repeat (3) @(posedge SCLK);
        #1;
        check("reset wr_done", wr_done_a, 0);
        check("reset rd_done", rd_done_a, 0);
        check("reset last_addr", last_addr_a, 0);
        check("reset last_data", last_data_a, 0);
        check("reset SDO", spi_a.SDO, 0);
        check("reset SDO_OE", {spi_a.SDO_OE, spi_b.SDO_OE}, 0);
        @(negedge SCLK);
        #1;
        Reset = 1'b0;
        @(posedge SCLK);

        for (int i = 0; i < NVEC; i++) begin
            is_rd = vecs[i].hdr[15];
            xfer({vecs[i].hdr, vecs[i].din, 16'h0000}, 24, EXTRA);
            check($sformatf("v%0d wr_done count a", i), wr_a, is_rd ? 0 : 1);
            check($sformatf("v%0d rd_done count a", i), rd_a, is_rd ? 1 : 0);
            check($sformatf("v%0d done pulse bit a", i), pos_a, 24);
            check($sformatf("v%0d SDO_OE edges a", i), oe_a, is_rd ? 8 : 0);
            check($sformatf("v%0d last_addr a", i), last_addr_a, vecs[i].hdr[11:0]);
            check($sformatf("v%0d last_data a", i), last_data_a, is_rd ? vecs[i].exp_a : vecs[i].din);
            check($sformatf("v%0d done counts b", i), {wr_b[7:0], rd_b[7:0]}, is_rd ? 16'h0001 : 16'h0100);
            check($sformatf("v%0d last_addr b", i), last_addr_b, vecs[i].hdr[11:0]);
            check($sformatf("v%0d last_data b", i), last_data_b, is_rd ? vecs[i].exp_b : vecs[i].din);
            if (is_rd) begin
                check($sformatf("v%0d SDO word a", i), word_a, {8'h00, vecs[i].exp_a});
                check($sformatf("v%0d SDO word b", i), word_b, {8'h00, vecs[i].exp_b});
                check($sformatf("v%0d SDO_OE edges b", i), oe_b, 8);
            end
        end

        // Frame aborted after 20 bits: nothing committed, 0x040 keeps 0x5A.
        xfer({16'h0040, 8'h3C, 16'h0000}, 20, 0);
        check("abort wr_done count", wr_a + wr_b, 0);
        check("abort last_data kept", last_data_a, 8'h81);
        check("abort last_addr kept", last_addr_a, 12'hFFF);
        xfer({16'h8040, 24'h000000}, 24, EXTRA);
        check("abort readback a", word_a, 16'h005A);
        check("abort readback b", word_b, 16'h005A);

        // Reset asserted at bit 10 of a write.
        for (int i = 0; i < 10; i++) begin
            clk_bit(i == 13 ? 1'b1 : 1'b0);
        end
        @(negedge SCLK);
        #1;
        Reset = 1'b1;
        #2;
        check("midreset last_addr", last_addr_a, 0);
        check("midreset last_data", last_data_a, 0);
        check("midreset done", {wr_done_a, rd_done_a, spi_a.SDO, spi_a.SDO_OE}, 0);
        @(negedge SCLK);
        #1;
        spi_a.SEN = 1'b1;
        Reset     = 1'b0;
        @(posedge SCLK);
        xfer({16'h0005, 8'h11, 16'h0000}, 24, EXTRA);
        check("post-reset wr_done count", wr_a, 1);
        check("post-reset last_addr", last_addr_a, 12'h005);
        check("post-reset last_data", last_data_a, 8'h11);
        xfer({16'h8005, 24'h000000}, 24, EXTRA);
        check("post-reset readback a", word_a, 16'h0011);
        check("post-reset readback b", word_b, 16'h0011);

`ifdef SPI_STREAM_EN
        xfer({16'h0FFF, 8'h11, 8'h22, 8'h00}, 32, 0);
        check("burst wr_done count a", wr_a, 2);
        check("burst wr_done count b", wr_b, 2);
        check("burst last_addr a", last_addr_a, 12'h000);
        check("burst last_data a", last_data_a, 8'h22);
        xfer({16'h8FFF, 24'h000000}, 32, 0);
        check("burst rd_done count a", rd_a, 2);
        check("burst SDO words a", word_a, 16'h1122);
        check("burst SDO words b", word_b, 16'h0022);
        check("burst read last_addr a", last_addr_a, 12'h000);
`else
        // Without bursts the second word is ignored.
        xfer({16'h0FFF, 8'h11, 8'h22, 8'h00}, 32, 0);
        check("single wr_done count a", wr_a, 1);
        check("single last_addr a", last_addr_a, 12'hFFF);
        check("single last_data a", last_data_a, 8'h11);
        xfer({16'h8FFF, 24'h000000}, 32, 0);
        check("single SDO word a", word_a, 16'h1100);
        check("single rd_done count a", rd_a, 1);
        check("single SDO_OE edges a", oe_a, 8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
